// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/result bundle for the iterative multiply/divide unit
interface mul_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, A, B, input busy, done, div_by_zero, hi, lo);
  modport slave  (input start, op, A, B, output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO and MTHI/MTLO
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic           clock,
  input logic           reset,
  mul_div_unit_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd, a_raw, hi_q, lo_q;
  logic               is_div, neg_lo, neg_hi, dbz, done_q, dz_q;

  logic               op_mul, op_div, is_signed, ge;
  logic [WIDTH-1:0]   a_abs, b_abs, rem_nx, quo, rem;
  logic [WIDTH:0]     psum, shifted;
  logic [2*WIDTH-1:0] prod_fix;

  assign op_mul    = (bus.op[2:1] == 2'b00);
  assign op_div    = (bus.op[2:1] == 2'b01);
  assign is_signed = ~bus.op[0];
  assign a_abs     = (is_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign b_abs     = (is_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;

  // acc holds {partial product, remaining multiplier bits} or {remainder, dividend/quotient bits}
  assign psum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign ge       = (shifted >= {1'b0, opnd});
  assign rem_nx   = ge ? (shifted[WIDTH-1:0] - opnd) : shifted[WIDTH-1:0];
  assign quo      = acc[WIDTH-1:0];
  assign rem      = acc[2*WIDTH-1:WIDTH];
  assign prod_fix = neg_lo ? -acc : acc;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (bus.start && op_mul)      state_nx = S_MUL;
        else if (bus.start && op_div) state_nx = S_DIV;
      end
      S_MUL, S_DIV: if (cnt == LAST) state_nx = S_FIN;
      S_FIN:        state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_raw  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      dbz    <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (op_mul || op_div) begin
              acc    <= {{WIDTH{1'b0}}, (op_div ? a_abs : b_abs)};
              opnd   <= op_div ? b_abs : a_abs;
              a_raw  <= bus.A;
              is_div <= op_div;
              neg_lo <= is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
              neg_hi <= is_signed & bus.A[WIDTH-1];
              dbz    <= op_div && (bus.B == '0);
              cnt    <= '0;
            end else if (bus.op == 3'b100) begin
              hi_q <= bus.A;
            end else if (bus.op == 3'b101) begin
              lo_q <= bus.A;
            end
          end
        end
        S_MUL: begin
          acc <= {psum, acc[WIDTH-1:1]};
          if (cnt != LAST) cnt <= cnt + CW'(1);
        end
        S_DIV: begin
          acc <= {rem_nx, acc[WIDTH-2:0], ge};
          if (cnt != LAST) cnt <= cnt + CW'(1);
        end
        S_FIN: begin
          done_q <= 1'b1;
          dz_q   <= dbz;
          if (is_div) begin
            lo_q <= dbz ? '1 : (neg_lo ? -quo : quo);
            hi_q <= dbz ? a_raw : (neg_hi ? -rem : rem);
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  // busy drops in FIN so the pipeline can release while the result is written back
  assign bus.busy        = (state == S_MUL) || (state == S_DIV);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - randomized and directed checks of mul_div_unit against a countdown reference model
module tb_mul_div_unit;
  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;

  mul_div_unit_if #(.WIDTH(32)) bus32 ();
  mul_div_unit_if #(.WIDTH(8))  bus8 ();

  mul_div_unit #(.WIDTH(32)) dut32 (.clock(clock), .reset(reset), .bus(bus32));
  mul_div_unit #(.WIDTH(8))  dut8  (.clock(clock), .reset(reset), .bus(bus8));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rh, output logic [31:0] rl, output logic rdz);
    logic signed [63:0] sp;
    logic [63:0]        up;
    int                 sa, sb;
    rdz = 1'b0;
    rh  = '0;
    rl  = '0;
    case (o)
      3'd0: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        {rh, rl} = sp;
      end
      3'd1: begin
        up = {32'd0, a} * {32'd0, b};
        {rh, rl} = up;
      end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          rl  = 32'hFFFF_FFFF;
          rh  = a;
          rdz = 1'b1;
        end else if (o == 3'd3) begin
          rl = a / b;
          rh = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          rl = 32'h8000_0000;
          rh = 32'd0;
        end else begin
          sa = a;
          sb = b;
          rl = sa / sb;
          rh = sa % sb;
        end
      end
      default: ;
    endcase
  endfunction

  // Model: a pending MUL/DIV is a countdown to its writeback edge; while it runs, starts are ignored.
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_busy = 0, m_done = 0, m_dz = 0, p_dz = 0;

  always @(posedge clock) begin
    m_done = 1'b0;
    m_dz   = 1'b0;
    if (reset) begin
      m_left = 0;
      m_hi   = '0;
      m_lo   = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi   = p_hi;
        m_lo   = p_lo;
        m_done = 1'b1;
        m_dz   = p_dz;
      end
    end else if (bus32.start) begin
      if (bus32.op <= 3'd3) begin
        ref_op(bus32.op, bus32.A, bus32.B, p_hi, p_lo, p_dz);
        m_left = 33;
      end else if (bus32.op == 3'd4) begin
        m_hi = bus32.A;
      end else if (bus32.op == 3'd5) begin
        m_lo = bus32.A;
      end
    end
    m_busy = (m_left >= 2);
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("cyc_busy", 32'(bus32.busy), 32'(m_busy));
      chk("cyc_done", 32'(bus32.done), 32'(m_done));
      chk("cyc_dz",   32'(bus32.div_by_zero), 32'(m_dz));
      chk("cyc_hi",   bus32.hi, m_hi);
      chk("cyc_lo",   bus32.lo, m_lo);
    end
  end

  task automatic issue32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus32.start = 1'b1;
    bus32.op    = o;
    bus32.A     = a;
    bus32.B     = b;
    @(negedge clock);
    bus32.start = 1'b0;
  endtask

  task automatic wait_done32(output int lat, output int bc);
    bc  = bus32.busy ? 1 : 0;
    lat = 0;
    while (!bus32.done && lat < 100) begin
      @(negedge clock);
      lat++;
      if (bus32.busy) bc++;
    end
  endtask

  task automatic run32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bc);
    issue32(o, a, b);
    wait_done32(lat, bc);
  endtask

  task automatic run8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clock);
    bus8.start = 1'b1;
    bus8.op    = o;
    bus8.A     = a;
    bus8.B     = b;
    @(negedge clock);
    bus8.start = 1'b0;
    lat = 0;
    while (!bus8.done && lat < 100) begin
      @(negedge clock);
      lat++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, bc;
    reset       = 1'b1;
    bus32.start = 1'b0;
    bus32.op    = '0;
    bus32.A     = '0;
    bus32.B     = '0;
    bus8.start  = 1'b0;
    bus8.op     = '0;
    bus8.A      = '0;
    bus8.B      = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(bus32.busy), 32'd0);
    chk("rst_done", 32'(bus32.done), 32'd0);
    chk("rst_dz",   32'(bus32.div_by_zero), 32'd0);
    chk("rst_hi",   bus32.hi, 32'd0);
    chk("rst_lo",   bus32.lo, 32'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    run32(3'd0, 32'd8, 32'd5, lat, bc);
    chk("t1_latency", 32'(lat), 32'd33);
    chk("t1_busy_cycles", 32'(bc), 32'd32);
    chk("t1_hi", bus32.hi, 32'd0);
    chk("t1_lo", bus32.lo, 32'h28);

    run32(3'd0, 32'hFFFF_FFF8, 32'd5, lat, bc);
    chk("t2_mult_hi", bus32.hi, 32'hFFFF_FFFF);
    chk("t2_mult_lo", bus32.lo, 32'hFFFF_FFD8);
    run32(3'd1, 32'hFFFF_FFF8, 32'd5, lat, bc);
    chk("t2_multu_hi", bus32.hi, 32'h4);
    chk("t2_multu_lo", bus32.lo, 32'hFFFF_FFD8);

    run32(3'd3, 32'd8, 32'd5, lat, bc);
    chk("t3_divu_lo", bus32.lo, 32'd1);
    chk("t3_divu_hi", bus32.hi, 32'd3);
    chk("t3_divu_dz", 32'(bus32.div_by_zero), 32'd0);
    run32(3'd2, 32'hFFFF_FFF8, 32'd5, lat, bc);
    chk("t3_div_lo", bus32.lo, 32'hFFFF_FFFF);
    chk("t3_div_hi", bus32.hi, 32'hFFFF_FFFD);
    chk("t3_div_dz", 32'(bus32.div_by_zero), 32'd0);

    run32(3'd2, 32'h1234, 32'd0, lat, bc);
    chk("t4_dz_flag", 32'(bus32.div_by_zero), 32'd1);
    chk("t4_dz_lo", bus32.lo, 32'hFFFF_FFFF);
    chk("t4_dz_hi", bus32.hi, 32'h1234);
    run32(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    chk("t4_ovf_lo", bus32.lo, 32'h8000_0000);
    chk("t4_ovf_hi", bus32.hi, 32'd0);

    issue32(3'd0, 32'd7, 32'd9);
    repeat (8) @(negedge clock);
    issue32(3'd3, 32'd100, 32'd7);
    wait_done32(lat, bc);
    chk("t5_ignored_latency", 32'(lat + 10), 32'd33);
    chk("t5_intact_lo", bus32.lo, 32'h3F);
    chk("t5_intact_hi", bus32.hi, 32'd0);
    issue32(3'd5, 32'hABCD, 32'd0);
    chk("t5_mtlo_lo", bus32.lo, 32'hABCD);
    chk("t5_mtlo_busy", 32'(bus32.busy), 32'd0);
    chk("t5_mtlo_done", 32'(bus32.done), 32'd0);

    issue32(3'd2, 32'd1000, 32'd7);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("t6_rst_busy", 32'(bus32.busy), 32'd0);
    chk("t6_rst_done", 32'(bus32.done), 32'd0);
    chk("t6_rst_hi", bus32.hi, 32'd0);
    chk("t6_rst_lo", bus32.lo, 32'd0);
    repeat (40) @(negedge clock);

    run8(3'd0, 8'd8, 8'd5, lat);
    chk("t6_w8_latency", 32'(lat), 32'd9);
    chk("t6_w8_lo", 32'(bus8.lo), 32'h28);
    chk("t6_w8_hi", 32'(bus8.hi), 32'd0);
    run8(3'd2, 8'hF8, 8'h05, lat);
    chk("t6_w8_div_lo", 32'(bus8.lo), 32'hFF);
    chk("t6_w8_div_hi", 32'(bus8.hi), 32'hFD);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      bus32.start = ($urandom % 4 == 0);
      bus32.op    = 3'($urandom % 8);
      bus32.A     = pick();
      bus32.B     = pick();
      reset       = ($urandom % 600 == 0);
    end
    @(negedge clock);
    bus32.start = 1'b0;
    reset       = 1'b0;
    repeat (40) @(negedge clock);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
